// File: rtl/bit_serial_adder.sv
// Bit-serial unsigned adder: one full-adder step per clock, LSB first,
// with a start/busy/done handshake and a registered result.
`timescale 1ns/1ps
module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Handshake: start is accepted on a rising edge only in IDLE or DONE;
   // busy is high for the WIDTH cycles of RUN, done pulses for one cycle
   // when sum/carry_out take their new value, start during RUN is ignored.
   state_t           state_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt_q;
   logic             c_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;

   logic             hs;
   logic             hc;
   logic             s_d;
   logic             c_d;
   logic [WIDTH-1:0] res_d;

   // Half adder on the current bit pair, then fold in the carry flop.
   assign hs    = a_sr_q[0] ^ b_sr_q[0];
   assign hc    = a_sr_q[0] & b_sr_q[0];
   assign s_d   = hs ^ c_q;
   assign c_d   = hc | (c_q & hs);
   assign res_d = {s_d, res_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_sr_q  <= a;
                  b_sr_q  <= b;
                  res_q   <= '0;
                  c_q     <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_sr_q <= a_sr_q >> 1;
               b_sr_q <= b_sr_q >> 1;
               res_q  <= res_d;
               c_q    <= c_d;
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  sum_q   <= res_d;
                  carry_q <= c_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sum       = sum_q;
   assign carry_out = carry_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: an 8-bit and a 4-bit instance checked each cycle
// against a cycle-arithmetic model, plus literal results for directed cases.
`timescale 1ns/1ps
module tb_bit_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start4;
   logic [7:0] a8, b8, sum8;
   logic [3:0] a4, b4, sum4;
   logic       cout8, busy8, done8, cout4, busy4, done4;
   logic [1:0] dbg8, dbg4;

   int total = 0;
   int bad   = 0;
   int done_cnt8 = 0;

   always #5 clk = ~clk;

   bit_serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .sum(sum8), .carry_out(cout8), .busy(busy8), .done(done8), .state_dbg(dbg8)
   );

   bit_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .sum(sum4), .carry_out(cout4), .busy(busy4), .done(done4), .state_dbg(dbg4)
   );

   // Model: edge count since reset; an op accepted at edge E is busy for
   // cycles E..E+W-1 and delivers a+b with done in cycle E+W.
   int          cyc = 0;
   int          mw[2]      = '{8, 4};
   int          m_start[2] = '{-1000, -1000};
   logic [32:0] m_pend[2];
   logic [31:0] m_sum[2]   = '{32'd0, 32'd0};
   logic        m_c[2]     = '{1'b0, 1'b0};

   function automatic bit m_busy_at(input int k, input int c);
      return (c >= m_start[k]) && (c <= m_start[k] + mw[k] - 1);
   endfunction

   task automatic model_edge(input int k, input logic st, input logic [31:0] av, input logic [31:0] bv);
      bit prev_busy;
      prev_busy = m_busy_at(k, cyc - 1);
      if (!prev_busy && st) begin
         m_start[k] = cyc;
         m_pend[k]  = {1'b0, av} + {1'b0, bv};
      end
      if (cyc == m_start[k] + mw[k]) begin
         m_sum[k] = m_pend[k][31:0] & ((32'd1 << mw[k]) - 32'd1);
         m_c[k]   = m_pend[k][mw[k]];
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc = 0;
         for (int k = 0; k < 2; k++) begin
            m_start[k] = -1000;
            m_sum[k]   = '0;
            m_c[k]     = 1'b0;
         end
      end else begin
         cyc = cyc + 1;
         model_edge(0, start8, {24'd0, a8}, {24'd0, b8});
         model_edge(1, start4, {28'd0, a4}, {28'd0, b4});
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("busy8", busy8, m_busy_at(0, cyc));
      check("done8", done8, cyc == m_start[0] + 8);
      check("sum8",  sum8,  m_sum[0]);
      check("cout8", cout8, m_c[0]);
      check("busy4", busy4, m_busy_at(1, cyc));
      check("done4", done4, cyc == m_start[1] + 4);
      check("sum4",  sum4,  m_sum[1]);
      check("cout4", cout4, m_c[1]);
      if (done8 === 1'b1) done_cnt8++;
   end

   // Waits for done on instance k; n = negedges after the start edge (-1 on timeout).
   task automatic wait_done(input int k, input int limit, output int n, output int bcnt);
      n = -1;
      bcnt = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if ((k == 0) ? done8 : done4) begin
            n = i;
            break;
         end
         if ((k == 0) ? busy8 : busy4) bcnt++;
      end
   endtask

   // Entered and left at posedge+2.
   task automatic run8(input string nm, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] es, input logic ec);
      int lat, bcnt;
      start8 = 1'b1; a8 = av; b8 = bv;
      @(posedge clk); #2;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      wait_done(0, 20, lat, bcnt);
      check({nm, "_lat"},  lat,   8);
      check({nm, "_busy"}, bcnt,  8);
      check({nm, "_sum"},  sum8,  es);
      check({nm, "_cout"}, cout8, ec);
      @(posedge clk); #2;
   endtask

   task automatic async_rst(input string nm);
      rst = 1'b1;
      #1;
      check({nm, "_sum"},  sum8,  0);
      check({nm, "_cout"}, cout8, 0);
      check({nm, "_busy"}, busy8, 0);
      check({nm, "_done"}, done8, 0);
      @(posedge clk); #2;
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, bcnt, d;
      logic [3:0] x, y;
      int s;
      rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
      a8 = '0; b8 = '0; a4 = '0; b4 = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("rst_sum8", sum8, 0);
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      @(posedge clk); #2;

      run8("add5a3c", 8'h5A, 8'h3C, 8'h96, 1'b0);
      run8("add0000", 8'h00, 8'h00, 8'h00, 1'b0);
      run8("addff01", 8'hFF, 8'h01, 8'h00, 1'b1);
      run8("addffff", 8'hFF, 8'hFF, 8'hFE, 1'b1);
      async_rst("idle_rst");

      // start pulsed during RUN must be ignored
      run8("pre", 8'h11, 8'h22, 8'h33, 1'b0);
      d = done_cnt8;
      start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
      @(posedge clk); #2 start8 = 1'b0;
      repeat (2) @(posedge clk);
      #2 start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      @(posedge clk); #2 start8 = 1'b0;
      wait_done(0, 20, n, bcnt);
      check("ign_sum", sum8, 8'h30);
      check("ign_cout", cout8, 1'b0);
      repeat (12) @(posedge clk);
      #2 check("ign_one_done", done_cnt8 - d, 1);

      // reset in the middle of an operation
      start8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
      @(posedge clk); #2 start8 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      d = done_cnt8;
      async_rst("mid_rst");
      repeat (12) @(posedge clk);
      #2 check("mid_no_done", done_cnt8 - d, 0);
      run8("add0102", 8'h01, 8'h02, 8'h03, 1'b0);

      // back-to-back with start held high
      start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      @(posedge clk); #2 a8 = 8'h7F; b8 = 8'h01;
      wait_done(0, 20, n, bcnt);
      check("b2b_lat1", n, 8);
      check("b2b_sum1", sum8, 8'h02);
      @(posedge clk); #2 start8 = 1'b0;
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done8) begin
            n = i;
            break;
         end
         check("b2b_hold", sum8, 8'h02);
      end
      check("b2b_gap", n, 9);
      check("b2b_sum2", sum8, 8'h80);
      check("b2b_cout2", cout8, 1'b0);
      @(posedge clk); #2;

      // random traffic, checked by the per-cycle model
      for (int i = 0; i < 400; i++) begin
         start8 = 1'($urandom_range(0, 1));
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         @(posedge clk); #2;
      end
      start8 = 1'b0;
      repeat (12) @(posedge clk);
      #2;

      // exhaustive 4-bit, back-to-back with start held high
      start4 = 1'b1;
      for (int p = 0; p < 256; p++) begin
         x = 4'(p >> 4);
         y = 4'(p & 15);
         a4 = x; b4 = y;
         @(posedge clk); #2;
         a4 = 4'($urandom); b4 = 4'($urandom);
         wait_done(1, 10, n, bcnt);
         s = int'(x) + int'(y);
         check("ex4_lat", n, 4);
         check("ex4_sum", sum4, s & 15);
         check("ex4_cout", cout4, s >> 4);
      end
      start4 = 1'b0;
      repeat (8) @(posedge clk);
      #2;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
